// File: rtl/spi_command_dispatcher.sv
// Decodes completed SPI command8/address16/data32 transactions into RAM write, read-back and block-fill operations.
// Optional macro SPI_DISPATCH_ADDRESS_CHECK_EN rejects addresses beyond the RAM depth instead of aliasing them.
module spi_command_dispatcher #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset_active_low,
    input  logic                  transaction_valid,
    input  logic [7:0]            command8,
    input  logic [15:0]           address16,
    input  logic [DATA_WIDTH-1:0] data32,
    output logic                  ram_write_enable,
    output logic [ADDR_WIDTH-1:0] ram_write_address,
    output logic [DATA_WIDTH-1:0] ram_write_data,
    output logic [ADDR_WIDTH-1:0] ram_read_address,
    input  logic [DATA_WIDTH-1:0] ram_read_data,
    output logic [DATA_WIDTH-1:0] data32_to_master,
    output logic                  busy,
    output logic [7:0]            error_count
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ_WAIT,
        FILL
    } state_t;

    localparam logic [7:0]            CMD_NOP   = 8'h00;
    localparam logic [7:0]            CMD_WRITE = 8'h01;
    localparam logic [7:0]            CMD_READ  = 8'h02;
    localparam logic [7:0]            CMD_FILL  = 8'h03;
    localparam logic [ADDR_WIDTH-1:0] MAX_ADDR  = '1;
    localparam logic [1:0]            LAST_WAIT = 2'(READ_LATENCY);

    state_t     state;
    state_t     state_next;
    logic [1:0] wait_count;
    logic       idle;
    logic       addr_in_range;
    logic       is_mem_cmd;
    logic       start_write;
    logic       start_read;
    logic       start_fill;
    logic       reject;
    logic       capture;
    logic       last_fill;

`ifdef SPI_DISPATCH_ADDRESS_CHECK_EN
    localparam logic [16:0] ADDR_LIMIT = 17'(2 ** ADDR_WIDTH);
`else
    // Upper address bits are deliberately dropped so out-of-range addresses alias.
    logic unused_address_bits;
    assign unused_address_bits = ^address16[15:ADDR_WIDTH];
`endif

    assign busy = (state != IDLE);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        addr_in_range = 1'b1;
`ifdef SPI_DISPATCH_ADDRESS_CHECK_EN
        addr_in_range = ({1'b0, address16} < ADDR_LIMIT);
`endif
        idle        = (state == IDLE);
        is_mem_cmd  = (command8 == CMD_WRITE) || (command8 == CMD_READ) || (command8 == CMD_FILL);
        start_write = transaction_valid && idle && (command8 == CMD_WRITE) && addr_in_range;
        start_read  = transaction_valid && idle && (command8 == CMD_READ)  && addr_in_range;
        start_fill  = transaction_valid && idle && (command8 == CMD_FILL)  && addr_in_range;
        reject      = transaction_valid &&
                      (!idle || (!is_mem_cmd && command8 != CMD_NOP) || (is_mem_cmd && !addr_in_range));
        capture     = (state == READ_WAIT) && (wait_count == LAST_WAIT);
        last_fill   = (state == FILL) && (ram_write_address == MAX_ADDR);

        state_next = state;
        case (state)
            IDLE: begin
                if (start_write)     state_next = WRITE;
                else if (start_read) state_next = READ_WAIT;
                else if (start_fill) state_next = FILL;
            end
            WRITE:     state_next = IDLE;
            READ_WAIT: if (capture)   state_next = IDLE;
            FILL:      if (last_fill) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_active_low) begin
        if (!reset_active_low) state <= IDLE;
        else                   state <= state_next;
    end

    always_ff @(posedge clock or negedge reset_active_low) begin
        if (!reset_active_low) begin
            ram_write_enable  <= 1'b0;
            ram_write_address <= '0;
            ram_write_data    <= '0;
            ram_read_address  <= '0;
            data32_to_master  <= '0;
            error_count       <= '0;
            wait_count        <= '0;
        end else begin
            // The write address register doubles as the fill pointer; the strobe stays high through a fill.
            if (start_write || start_fill) begin
                ram_write_enable  <= 1'b1;
                ram_write_address <= address16[ADDR_WIDTH-1:0];
                ram_write_data    <= data32;
            end else if (state == FILL && !last_fill) begin
                ram_write_address <= ram_write_address + 1'b1;
            end else begin
                ram_write_enable <= 1'b0;
            end

            if (start_read) begin
                ram_read_address <= address16[ADDR_WIDTH-1:0];
                wait_count       <= '0;
            end else if (state == READ_WAIT) begin
                wait_count <= wait_count + 2'd1;
            end

            if (capture) data32_to_master <= ram_read_data;

            if (reject && error_count != 8'hFF) error_count <= error_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_spi_command_dispatcher.sv
// Scoreboard bench for spi_command_dispatcher: stimulus queues expected writes/operations, a negedge monitor checks them.
module tb_spi_command_dispatcher;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int RL = 1;

    logic          clock = 1'b0;
    logic          reset_active_low;
    logic          transaction_valid;
    logic [7:0]    command8;
    logic [15:0]   address16;
    logic [DW-1:0] data32;
    logic          ram_write_enable;
    logic [AW-1:0] ram_write_address;
    logic [DW-1:0] ram_write_data;
    logic [AW-1:0] ram_read_address;
    logic [DW-1:0] ram_read_data;
    logic [DW-1:0] data32_to_master;
    logic          busy;
    logic [7:0]    error_count;

    always #5 clock = ~clock;

    spi_command_dispatcher #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)) dut (
        .clock             (clock),
        .reset_active_low  (reset_active_low),
        .transaction_valid (transaction_valid),
        .command8          (command8),
        .address16         (address16),
        .data32            (data32),
        .ram_write_enable  (ram_write_enable),
        .ram_write_address (ram_write_address),
        .ram_write_data    (ram_write_data),
        .ram_read_address  (ram_read_address),
        .ram_read_data     (ram_read_data),
        .data32_to_master  (data32_to_master),
        .busy              (busy),
        .error_count       (error_count)
    );

    function automatic logic [31:0] init_word(input logic [7:0] a);
        return 32'hA500_0000 | {24'd0, a};
    endfunction

    // Behavioural RAM with READ_LATENCY-cycle read pipeline; unwritten words read as init_word.
    logic [31:0] ram_store   [256];
    bit          ram_written [256];
    logic [31:0] rd_pipe     [RL];
    always @(posedge clock) begin
        if (ram_write_enable) begin
            ram_store[ram_write_address]   <= ram_write_data;
            ram_written[ram_write_address] <= 1'b1;
        end
        rd_pipe[0] <= ram_written[ram_read_address] ? ram_store[ram_read_address]
                                                    : init_word(ram_read_address);
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_read_data = rd_pipe[RL-1];

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;
    typedef struct {
        int          len;
        logic [31:0] d2m;
    } op_t;

    wr_t         wr_q[$];
    op_t         op_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_mem  [256];
    logic [31:0] snap_mem [256];
    logic [31:0] exp_d2m;
    logic [7:0]  exp_errors;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: every strobe must match the next queued write; every busy window must match the next queued op.
    bit prev_busy = 1'b0;
    int busy_run  = 0;
    always @(negedge clock) begin : monitor
        wr_t w;
        op_t o;
        if (!reset_active_low) begin
            prev_busy = 1'b0;
            busy_run  = 0;
        end else begin
            if (ram_write_enable) begin
                if (wr_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_write: addr 0x%02h data 0x%08h, no write expected at %0t",
                             ram_write_address, ram_write_data, $time);
                end else begin
                    w = wr_q.pop_front();
                    check("write_addr", {24'd0, ram_write_address}, {24'd0, w.addr});
                    check("write_data", ram_write_data, w.data);
                end
            end
            if (busy) busy_run++;
            if (prev_busy && !busy) begin
                if (op_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_busy: %0d busy cycles, no operation expected at %0t", busy_run, $time);
                end else begin
                    o = op_q.pop_front();
                    check("busy_cycles", busy_run, o.len);
                    check("data32_to_master", data32_to_master, o.d2m);
                end
                busy_run = 0;
            end
            prev_busy = busy;
        end
    end

    // Predicts the outcome of one transaction, queues expectations, then drives a one-cycle pulse.
    task automatic issue(input logic [7:0] cmd, input logic [15:0] addr, input logic [31:0] data, input bit busy_now);
        logic [7:0] a;
        bit         bad_addr;
        bit         mem_cmd;
        op_t        o;
        a        = addr[7:0];
        mem_cmd  = (cmd == 8'h01) || (cmd == 8'h02) || (cmd == 8'h03);
        bad_addr = 1'b0;
`ifdef SPI_DISPATCH_ADDRESS_CHECK_EN
        bad_addr = (addr > 16'h00FF);
`endif
        if (busy_now || cmd > 8'h03 || (mem_cmd && bad_addr)) begin
            if (exp_errors != 8'hFF) exp_errors++;
        end else if (cmd == 8'h01) begin
            wr_q.push_back('{addr: a, data: data});
            exp_mem[a] = data;
            o.len = 1;
            o.d2m = exp_d2m;
            op_q.push_back(o);
        end else if (cmd == 8'h02) begin
            exp_d2m = exp_mem[a];
            o.len = RL + 1;
            o.d2m = exp_d2m;
            op_q.push_back(o);
        end else if (cmd == 8'h03) begin
            for (int i = a; i < 256; i++) begin
                wr_q.push_back('{addr: 8'(i), data: data});
                exp_mem[i] = data;
            end
            o.len = 256 - int'(a);
            o.d2m = exp_d2m;
            op_q.push_back(o);
        end
        @(negedge clock);
        transaction_valid = 1'b1;
        command8          = cmd;
        address16         = addr;
        data32            = data;
        @(negedge clock);
        transaction_valid = 1'b0;
        command8          = 8'h00;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clock);
            n++;
        end
        check("idle_within_budget", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},      {31'd0, busy},             32'd0);
        check({tag, "_we"},        {31'd0, ram_write_enable}, 32'd0);
        check({tag, "_waddr"},     {24'd0, ram_write_address}, 32'd0);
        check({tag, "_wdata"},     ram_write_data,            32'd0);
        check({tag, "_raddr"},     {24'd0, ram_read_address},  32'd0);
        check({tag, "_d2m"},       data32_to_master,          32'd0);
        check({tag, "_errors"},    {24'd0, error_count},       32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n;
        reset_active_low  = 1'b0;
        transaction_valid = 1'b0;
        command8          = 8'h00;
        address16         = 16'h0000;
        data32            = 32'h0;
        exp_d2m           = 32'h0;
        exp_errors        = 8'h00;
        for (int i = 0; i < 256; i++) exp_mem[i] = init_word(8'(i));

        repeat (3) @(negedge clock);
        check_all_zero("reset");
        @(posedge clock);
        #2 reset_active_low = 1'b1;

        // Write then read back; NOP is not an error.
        issue(8'h01, 16'h0001, 32'h0123_4567, 1'b0); wait_idle(10);
        issue(8'h02, 16'h0001, 32'h0,         1'b0); wait_idle(10);
        issue(8'h00, 16'h0055, 32'hFFFF_FFFF, 1'b0); wait_idle(10);
        check("error_count_t1", {24'd0, error_count}, {24'd0, exp_errors});

        // Fill near the top of memory: 4 writes, then read inside and just outside the range.
        issue(8'h03, 16'h00FC, 32'hDEAD_BEEF, 1'b0); wait_idle(20);
        issue(8'h02, 16'h00FE, 32'h0, 1'b0); wait_idle(10);
        issue(8'h02, 16'h0000, 32'h0, 1'b0); wait_idle(10);
        issue(8'h02, 16'h00FB, 32'h0, 1'b0); wait_idle(10);
        issue(8'h03, 16'h00FF, 32'h7777_0001, 1'b0); wait_idle(10);

        // Illegal command, then a write dropped while a full fill runs.
        issue(8'h7F, 16'h0000, 32'h0, 1'b0); wait_idle(5);
        issue(8'h03, 16'h0000, 32'h5A5A_0F0F, 1'b0);
        issue(8'h01, 16'h0010, 32'h1111_1111, 1'b1);
        wait_idle(300);
        check("error_count_t3", {24'd0, error_count}, {24'd0, exp_errors});
        issue(8'h02, 16'h0010, 32'h0, 1'b0); wait_idle(10);
        issue(8'h02, 16'h00FF, 32'h0, 1'b0); wait_idle(10);

        // Out-of-range address: alias or reject depending on the build.
        issue(8'h01, 16'h0101, 32'h89AB_CDEF, 1'b0); wait_idle(10);
        issue(8'h02, 16'h0001, 32'h0, 1'b0); wait_idle(10);
        issue(8'h02, 16'h0101, 32'h0, 1'b0); wait_idle(10);
        check("error_count_t4", {24'd0, error_count}, {24'd0, exp_errors});

        // Reset in the middle of a fill; the strobe at 0x40 is killed before its commit edge.
        for (int i = 0; i < 256; i++) snap_mem[i] = exp_mem[i];
        issue(8'h03, 16'h0000, 32'hC0FF_EE00, 1'b0);
        n = 0;
        while (!(ram_write_enable && ram_write_address == 8'h40) && n < 400) begin
            @(negedge clock);
            n++;
        end
        check("fill_reached_0x40", {24'd0, ram_write_address}, 32'h40);
        #2 reset_active_low = 1'b0;
        wr_q.delete();
        op_q.delete();
        for (int i = 8'h40; i < 256; i++) exp_mem[i] = snap_mem[i];
        exp_d2m    = 32'h0;
        exp_errors = 8'h00;
        #1 check_all_zero("midfill_reset");
        repeat (3) @(posedge clock);
        #2 reset_active_low = 1'b1;
        repeat (10) @(negedge clock);
        check_all_zero("after_release");
        issue(8'h01, 16'h0020, 32'h1357_9BDF, 1'b0); wait_idle(10);
        issue(8'h02, 16'h0020, 32'h0, 1'b0); wait_idle(10);
        issue(8'h02, 16'h003F, 32'h0, 1'b0); wait_idle(10);
        issue(8'h02, 16'h0040, 32'h0, 1'b0); wait_idle(10);

        // Saturation of the error counter.
        for (int i = 0; i < 300; i++) begin
            issue(8'(4 + (i % 252)), 16'h0000, 32'h0, 1'b0);
            if (i == 253) check("error_count_254", {24'd0, error_count}, {24'd0, exp_errors});
        end
        check("error_count_saturated", {24'd0, error_count}, 32'hFF);
        issue(8'h02, 16'h00FE, 32'h0, 1'b0); wait_idle(10);

        repeat (3) @(negedge clock);
        check("pending_writes", wr_q.size(), 32'd0);
        check("pending_ops",    op_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
